// File: rtl/fd_instr_queue_pkg.sv
// Shared constants and types for the fetch/decode instruction queue.
// The fetch stage's PC reset value must come from RESET_PC here.
package fd_instr_queue_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fd_entry_t;

endpackage

// File: rtl/fd_queue_ram.sv
// DEPTH x {pc, instr} register array: one synchronous write port and
// one combinational read port. Contents are never reset.
module fd_queue_ram
  import fd_instr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fd_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output fd_entry_t        rdata
);

  fd_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fd_instr_queue.sv
// First-word-fall-through queue between fetch and decode. Accepts a push
// only when not full (independent of d_ready) and supports a full flush.
module fd_instr_queue
  import fd_instr_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PTR_W    = 2,
  parameter logic [XLEN-1:0] RESET_PC = fd_instr_queue_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  input  logic [XLEN-1:0] f_instr,
  output logic            f_ready,
  output logic            d_valid,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_instr,
  input  logic            d_ready,
  input  logic            flush,
  output logic [PTR_W:0]  count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop, clr;
  fd_entry_t        wdata, rdata;

  assign f_ready = (cnt_q != FULL);
  assign d_valid = (cnt_q != '0);
  assign clr     = reset | flush;
  assign push    = f_valid & f_ready & ~clr;
  assign pop     = d_valid & d_ready & ~clr;
  assign count   = cnt_q;

  assign wdata.pc    = f_pc;
  assign wdata.instr = f_instr;

  fd_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Empty queue presents the reset PC and a nop so no stale/X data leaks.
  assign d_pc    = d_valid ? rdata.pc    : RESET_PC;
  assign d_instr = d_valid ? rdata.instr : NOP;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed plus randomized bench for fd_instr_queue against a queue-based
// reference model of the FIFO rules.
module tb_fd_instr_queue;
  import fd_instr_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            f_valid = 1'b0;
  logic [31:0]     f_pc = '0;
  logic [31:0]     f_instr = '0;
  logic            f_ready;
  logic            d_valid;
  logic [31:0]     d_pc;
  logic [31:0]     d_instr;
  logic            d_ready = 1'b0;
  logic            flush = 1'b0;
  logic [PTR_W:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mq[$];
  logic [31:0] pc_run;

  fd_instr_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_valid (f_valid),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_pc    (d_pc),
    .d_instr (d_instr),
    .d_ready (d_ready),
    .flush   (flush),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_pc, e_in;
    e_pc = (mq.size() == 0) ? 32'h0000_3000 : mq[0][63:32];
    e_in = (mq.size() == 0) ? 32'h0 : mq[0][31:0];
    chk("count",   32'(count),   32'(mq.size()));
    chk("f_ready", 32'(f_ready), 32'(mq.size() != DEPTH));
    chk("d_valid", 32'(d_valid), 32'(mq.size() != 0));
    chk("d_pc",    d_pc,    e_pc);
    chk("d_instr", d_instr, e_in);
  endtask

  // One clock: drive inputs, update model at the edge, check at negedge.
  task automatic cyc(input logic r, input logic fl, input logic fv,
                     input logic [31:0] pc, input logic [31:0] ins, input logic dr);
    bit do_push, do_pop;
    reset = r; flush = fl; f_valid = fv; f_pc = pc; f_instr = ins; d_ready = dr;
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
    end else begin
      do_push = fv && (mq.size() < DEPTH);
      do_pop  = dr && (mq.size() > 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // 1: reset then idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_pc", d_pc, 32'h0000_3000);

    // 2: single push, then pop
    cyc(0, 0, 1, 32'h3000, 32'hAAAA_0001, 0);
    chk("t2_head", d_instr, 32'hAAAA_0001);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t2_empty", 32'(count), 32'd0);

    // 3: fill, offer while full, drain
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h3000 + 32'(4*i), 32'hB000_0000 + 32'(i), 0);
    chk("t3_full", 32'(f_ready), 32'd0);
    cyc(0, 0, 1, 32'h3010, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_seq", d_pc, 32'h3000 + 32'(4*i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("t3_drained", 32'(d_valid), 32'd0);

    // 4: streaming push+pop with pointer wrap
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 32'h3000 + 32'(4*i), 32'hC000_0000 + 32'(i), 1);
      chk("t4_pc", d_pc, 32'h3000 + 32'(4*i));
    end
    cyc(0, 0, 0, 0, 0, 1);

    // 5: flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h3020 + 32'(4*i), 32'(i), 0);
    cyc(0, 1, 1, 32'h3040, 32'h1111_2222, 1);
    chk("t5_flushed", 32'(count), 32'd0);
    cyc(0, 0, 1, 32'h3040, 32'h1111_2222, 0);
    chk("t5_head", d_pc, 32'h3040);
    cyc(0, 0, 0, 0, 0, 1);

    // 6: reset mid-operation with f_valid
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 32'h3100 + 32'(4*i), 32'(i), 0);
    cyc(1, 0, 1, 32'h3200, 32'h5555_5555, 0);
    chk("t6_pc", d_pc, 32'h0000_3000);

    // Random traffic
    pc_run = 32'h3000;
    for (int i = 0; i < 3000; i++) begin
      logic r, fl, fv, dr;
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 19) == 0);
      fv = ($urandom_range(0, 99) < 65);
      dr = ($urandom_range(0, 99) < 50);
      cyc(r, fl, fv, pc_run, $urandom, dr);
      if (fv && !r && !fl && f_ready) pc_run = pc_run + 32'd4;
      if (fv && f_ready) pc_run = pc_run + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fd_instr_queue.md
Name: fd_instr_queue

Overview:
- Decoupling buffer between the fetch stage (instruction-memory PC/instruction source) and the decode-stage pipeline register.
- Captures {PC, Instr} pairs from fetch and presents the oldest pair to decode in first-word-fall-through order.
- Lets a decode stall be absorbed without stalling fetch until the buffer fills.
- Supports a full flush for redirects.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- RESET_PC, 32'h0000_3000, value of d_pc when the queue is empty.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch presents a valid pair this cycle.
- f_pc  in  32  PC of the fetched instruction.
- f_instr  in  32  fetched instruction word.
- f_ready  out  1  queue can accept a push; fetch uses it as its PC-advance enable.
- d_valid  out  1  head entry valid.
- d_pc  out  32  PC of the head entry.
- d_instr  out  32  instruction of the head entry.
- d_ready  in  1  decode consumes the head entry this cycle (not stalled).
- flush  in  1  discard all entries (branch/jump redirect).
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array {pc, instr}, wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH), occupancy counter cnt (PTR_W+1 bits).
- push = f_valid & f_ready; pop = d_valid & d_ready.
- f_ready = (cnt != DEPTH), combinational from registered cnt only. Never depends on d_ready, so there is no full-and-pop bypass.
- d_valid = (cnt != 0).
- d_pc and d_instr come from the array at rd_ptr when d_valid. When empty: d_pc = RESET_PC, d_instr = 32'h0000_0000 (nop).
- Latency: a pair pushed in cycle N is visible on d_* in cycle N+1. There is no same-cycle bypass from empty.
- Per rising edge, in priority order:
  - reset: wr_ptr=0, rd_ptr=0, cnt=0. Array contents are don't-care. Outputs become f_ready=1, d_valid=0, d_pc=RESET_PC, d_instr=0, count=0. Reset mid-operation discards all entries.
  - flush: same pointer and count clear as reset. A simultaneous push or pop is ignored; a pair offered in the flush cycle is dropped.
  - otherwise:
    - push only: write array[wr_ptr], wr_ptr+1, cnt+1.
    - pop only: rd_ptr+1, cnt-1.
    - push and pop (0<cnt<DEPTH): write, both pointers advance, cnt unchanged.
- Pointer wrap: index DEPTH-1 increments to 0.
- Boundary cases:
  - f_valid while full: no write, no pointer change. Fetch must hold its pair because f_ready=0.
  - d_ready while empty: no effect.
- Array is written only on push. No X may propagate to d_* when empty.

Decomposition:
- Shared package/header: RESET_PC (32'h0000_3000), NOP word (32'h0), instruction/PC width 32.
- The fetch stage's PC reset constant must use the same RESET_PC definition.
- One natural sub-module, fd_queue_ram: DEPTH x 64 register array with one synchronous write port and one combinational read port.
- Pointer, count and handshake logic stay in fd_instr_queue.

Test Plan:
1. Reset, then idle -> f_ready=1, d_valid=0, d_pc=32'h3000, d_instr=0, count=0.
2. Push {3000,AAAA0001} in cycle 1 with d_ready=0 -> cycle 2: d_valid=1, d_pc=3000, d_instr=AAAA0001, count=1. Assert d_ready in cycle 2 -> cycle 3: count=0, d_pc=3000, d_instr=0.
3. d_ready=0; push PCs 3000, 3004, 3008, 300C -> count=4, f_ready=0. Offer 3010 while full -> dropped. Pop 4 times -> d_pc sequence 3000, 3004, 3008, 300C, then empty.
4. Steady state, f_valid=d_ready=1 for 10 cycles starting at PC 3000 -> count stays at 1 after the fill cycle. Pointers wrap past index 3 with no loss and in-order PCs 3000..3024.
5. Queue holding 3 entries; flush=1 together with f_valid (pc 3040) and d_ready -> next cycle count=0, d_valid=0. Next push of 3040 appears as head after one cycle.
6. Queue holding 2 entries; reset asserted for one cycle while f_valid=1 -> next cycle count=0, f_ready=1, d_pc=3000, d_instr=0.
